// File: rtl/mbt_pkg.sv
// Shared constants, viewport defaults and dispatcher state encoding for the
// Mandelbrot renderer.
package mbt_pkg;
  localparam int N        = 32;
  localparam int Q        = 21;
  localparam int ITER_W   = 7;
  localparam int MAX_ITER = 99;

  localparam logic [N-1:0] ONE  = 32'h0020_0000;
  localparam logic [N-1:0] TWO  = 32'h0040_0000;
  localparam logic [N-1:0] FOUR = 32'h0080_0000;

  localparam logic [N-1:0] X_MIN_DEF = 32'hFFC0_0000;
  localparam logic [N-1:0] Y_MAX_DEF = 32'h0025_8000;
  localparam logic [N-1:0] STEP_DEF  = 32'h0000_2800;

  localparam logic [ITER_W-1:0] ITER_FORCED = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_WRITE, S_ADVANCE, S_DONE
  } disp_state_e;
endpackage

// File: rtl/mbt_coord_gen.sv
// Pixel walker: col/row counters, fixed-point coordinate accumulators and the
// linear frame-buffer address.
module mbt_coord_gen
  import mbt_pkg::*;
#(
  parameter int          N      = mbt_pkg::N,
  parameter int          H_RES  = 320,
  parameter int          V_RES  = 240,
  parameter logic [N-1:0] X_MIN = X_MIN_DEF,
  parameter logic [N-1:0] Y_MAX = Y_MAX_DEF,
  parameter logic [N-1:0] STEP  = STEP_DEF,
  parameter int          ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_advance,
  output logic [N-1:0]      o_c_real,
  output logic [N-1:0]      o_c_img,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col,
  output logic              o_last_pixel
);
  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [N-1:0]      r_c_real, r_c_img;
  logic [ADDR_W-1:0] r_addr;
  logic              w_last_row;

  assign o_last_col   = (r_col == COL_W'(H_RES - 1));
  assign w_last_row   = (r_row == ROW_W'(V_RES - 1));
  assign o_last_pixel = o_last_col & w_last_row;
  assign o_c_real     = r_c_real;
  assign o_c_img      = r_c_img;
  assign o_addr       = r_addr;

  // Coordinates wrap in N bits; the viewport parameters keep them in range.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_c_real <= X_MIN;
      r_c_img  <= Y_MAX;
      r_addr   <= '0;
    end else if (i_load) begin
      r_col    <= '0;
      r_row    <= '0;
      r_c_real <= X_MIN;
      r_c_img  <= Y_MAX;
      r_addr   <= '0;
    end else if (i_advance) begin
      r_addr <= r_addr + 1'b1;
      if (o_last_col) begin
        r_col    <= '0;
        r_row    <= r_row + 1'b1;
        r_c_real <= X_MIN;
        r_c_img  <= r_c_img - STEP;
      end else begin
        r_col    <= r_col + 1'b1;
        r_c_real <= r_c_real + STEP;
      end
    end
  end
endmodule

// File: rtl/mbt_pixel_dispatcher.sv
// Frame controller: walks every pixel, runs the ALU start/valid handshake with
// a bounded wait, and writes each iteration count to the frame buffer.
module mbt_pixel_dispatcher
  import mbt_pkg::*;
#(
  parameter int           N       = mbt_pkg::N,
  parameter int           Q       = mbt_pkg::Q,
  parameter int           H_RES   = 320,
  parameter int           V_RES   = 240,
  parameter logic [N-1:0] X_MIN   = X_MIN_DEF,
  parameter logic [N-1:0] Y_MAX   = Y_MAX_DEF,
  parameter logic [N-1:0] STEP    = STEP_DEF,
  parameter int           TIMEOUT = 1023,
  parameter int           ADDR_W  = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_timeout_err,
  output logic              o_alu_rst,
  output logic              o_alu_start,
  output logic [N-1:0]      o_alu_c_real,
  output logic [N-1:0]      o_alu_c_img,
  input  logic              i_alu_valid,
  input  logic [ITER_W-1:0] i_alu_iter,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [ITER_W-1:0] o_fb_data,
  input  logic              i_fb_ready
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  disp_state_e       r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_inc;
  logic [ITER_W-1:0] r_fb_data;
  logic              r_timeout_err;
  logic              w_timeout, w_load, w_advance, w_last_col, w_last_pixel;

  assign w_wait_inc = r_wait_cnt + 1'b1;
  assign w_timeout  = (w_wait_inc == WAIT_W'(TIMEOUT));
  assign w_load     = (r_state == S_IDLE) && i_frame_start;
  assign w_advance  = (r_state == S_ADVANCE) && !w_last_pixel;

  mbt_coord_gen #(
    .N(N), .H_RES(H_RES), .V_RES(V_RES), .X_MIN(X_MIN), .Y_MAX(Y_MAX),
    .STEP(STEP), .ADDR_W(ADDR_W)
  ) u_coord (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_advance   (w_advance),
    .o_c_real    (o_alu_c_real),
    .o_c_img     (o_alu_c_img),
    .o_addr      (o_fb_addr),
    .o_last_col  (w_last_col),
    .o_last_pixel(w_last_pixel)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_frame_start) w_state_nxt = S_CLR;
      S_CLR:     w_state_nxt = S_LAUNCH;
      S_LAUNCH:  w_state_nxt = S_WAIT;
      S_WAIT:    if (i_alu_valid || w_timeout) w_state_nxt = S_WRITE;
      S_WRITE:   if (i_fb_ready) w_state_nxt = S_ADVANCE;
      S_ADVANCE: w_state_nxt = (w_last_col && w_last_pixel) ? S_DONE : S_CLR;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_alu_rst    = (r_state == S_IDLE) || (r_state == S_CLR) || (r_state == S_DONE);
    o_alu_start  = (r_state == S_LAUNCH);
    o_fb_we      = (r_state == S_WRITE);
    o_frame_done = (r_state == S_DONE);
    o_busy       = (r_state != S_IDLE);
  end

  // A valid result in the same cycle as the timeout takes priority.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wait_cnt    <= '0;
      r_fb_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_load) r_timeout_err <= 1'b0;
      if (r_state == S_LAUNCH) r_wait_cnt <= '0;
      if (r_state == S_WAIT) begin
        r_wait_cnt <= w_wait_inc;
        if (i_alu_valid) begin
          r_fb_data <= i_alu_iter;
        end else if (w_timeout) begin
          r_fb_data     <= ITER_FORCED;
          r_timeout_err <= 1'b1;
        end
      end
    end
  end

  assign o_fb_data     = r_fb_data;
  assign o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_mbt_pixel_dispatcher.sv
// Randomized bench for the pixel dispatcher with a behavioural ALU and a
// frame-level reference of expected writes.
module tb_mbt_pixel_dispatcher;
  localparam int          H       = 4;
  localparam int          V       = 2;
  localparam logic [31:0] XMIN    = 32'hFFC0_0000;
  localparam logic [31:0] YMAX    = 32'h0025_8000;
  localparam logic [31:0] STP     = 32'h0010_0000;
  localparam int          TMO     = 15;
  localparam int          AW      = 17;

  logic        clk = 1'b0, rst = 1'b0, frame_start = 1'b0;
  logic        busy, frame_done, timeout_err, alu_rst, alu_start, fb_we;
  logic [31:0] c_real, c_img;
  logic        alu_valid = 1'b0;
  logic [6:0]  alu_iter = '0;
  logic [AW-1:0] fb_addr;
  logic [6:0]  fb_data;
  logic        fb_ready = 1'b0;

  int errors = 0, checks = 0;
  int cyc = 0, n_writes = 0, n_done = 0, exp_pix = 0;
  int ready_mode = 0;   // 0 random, 1 forced low, 2 forced high
  bit never_mode = 0;
  logic [6:0] salt = '0;

  mbt_pixel_dispatcher #(
    .H_RES(H), .V_RES(V), .X_MIN(XMIN), .Y_MAX(YMAX), .STEP(STP),
    .TIMEOUT(TMO), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start),
    .o_busy(busy), .o_frame_done(frame_done), .o_timeout_err(timeout_err),
    .o_alu_rst(alu_rst), .o_alu_start(alu_start),
    .o_alu_c_real(c_real), .o_alu_c_img(c_img),
    .i_alu_valid(alu_valid), .i_alu_iter(alu_iter),
    .o_fb_we(fb_we), .o_fb_addr(fb_addr), .o_fb_data(fb_data),
    .i_fb_ready(fb_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in ALU result: any fixed function of the coordinate will do.
  function automatic logic [6:0] alu_fn(logic [31:0] cr, logic [31:0] ci, logic [6:0] s);
    return 7'(cr[27:21] * 7'd3 + ci[26:20] + s);
  endfunction

  // Behavioural ALU: cleared by alu_rst, valid a random 1..6 cycles after start.
  int  alu_cnt = 0;
  bit  alu_armed = 0;
  always @(negedge clk) begin
    if (alu_rst) begin
      alu_valid = 1'b0;
      alu_armed = 0;
    end else if (alu_start) begin
      alu_cnt   = $urandom_range(1, 6);
      alu_armed = !never_mode;
      alu_iter  = alu_fn(c_real, c_img, salt);
    end else if (alu_armed) begin
      if (alu_cnt > 1) alu_cnt--;
      else begin
        alu_valid = 1'b1;
        alu_armed = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       fb_ready = ($urandom_range(0, 3) != 0);
      1:       fb_ready = 1'b0;
      default: fb_ready = 1'b1;
    endcase
  end

  // Reference: writes arrive in raster order with coordinates from the viewport.
  always @(negedge clk) begin
    if (!rst) exp_pix = 0;
    else begin
      if (fb_we && fb_ready) begin
        int col, row;
        logic [31:0] ecr, eci;
        col = exp_pix % H;
        row = exp_pix / H;
        ecr = XMIN + STP * col;
        eci = YMAX - STP * row;
        chk("wr_addr", fb_addr, exp_pix);
        chk("wr_c_real", c_real, ecr);
        chk("wr_c_img", c_img, eci);
        chk("wr_data", fb_data, never_mode ? 7'h7F : alu_fn(ecr, eci, salt));
        n_writes++;
        exp_pix++;
      end
      if (frame_done) begin
        n_done++;
        chk("pixels_per_frame", exp_pix, H * V);
        exp_pix = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic wait_done(int d0, int budget);
    for (int i = 0; i < budget && n_done == d0; i++) @(negedge clk);
    chk("frame_done_seen", n_done - d0, 1);
  endtask

  task automatic run_frame(string tag);
    int d0, w0;
    d0 = n_done;
    w0 = n_writes;
    salt = 7'($urandom);
    pulse_start();
    wait_done(d0, 3000);
    chk({tag, "_writes"}, n_writes - w0, H * V);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int d0, w0, t0, t1;
    logic [AW-1:0] a0;
    logic [6:0] dat0;

    repeat (3) @(negedge clk);
    chk("rst_alu_rst", alu_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_c_real", c_real, XMIN);
    chk("rst_c_img", c_img, YMAX);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("basic");
    chk("basic_terr", timeout_err, 0);
    for (int f = 0; f < 3; f++) run_frame("rand");

    // Timeout: ALU never answers
    never_mode = 1;
    d0 = n_done;
    pulse_start();
    t0 = -1;
    for (int i = 0; i < 100 && t0 < 0; i++) begin
      @(negedge clk);
      if (alu_start) t0 = cyc;
    end
    t1 = -1;
    for (int i = 0; i < 100 && t1 < 0; i++) begin
      @(negedge clk);
      if (fb_we) t1 = cyc;
    end
    chk("to_launch_to_write", t1 - t0, TMO + 1);
    wait_done(d0, 3000);
    @(negedge clk);
    chk("to_terr_sticky", timeout_err, 1);
    chk("to_busy_after", busy, 0);
    never_mode = 0;
    d0 = n_done;
    pulse_start();
    chk("to_terr_cleared", timeout_err, 0);
    wait_done(d0, 3000);
    chk("to_terr_clean_frame", timeout_err, 0);

    // Stalled frame buffer
    ready_mode = 1;
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    for (int i = 0; i < 100 && !fb_we; i++) @(negedge clk);
    a0 = fb_addr;
    dat0 = fb_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_we", fb_we, 1);
      chk("stall_addr", fb_addr, a0);
      chk("stall_data", fb_data, dat0);
    end
    chk("stall_no_write", n_writes - w0, 0);
    ready_mode = 0;
    wait_done(d0, 3000);
    chk("stall_writes", n_writes - w0, H * V);

    // frame_start while busy, then during DONE
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 3000 && !frame_done; i++) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    chk("done_start_ignored", busy, 0);
    repeat (40) @(negedge clk);
    chk("busy_start_done_cnt", n_done - d0, 1);
    chk("busy_start_writes", n_writes - w0, H * V);

    // Reset mid-WAIT
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 500 && !(alu_start && fb_addr == 2); i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk) #1;
    chk("mrst_alu_rst", alu_rst, 1);
    chk("mrst_fb_we", fb_we, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", fb_addr, 0);
    chk("mrst_c_real", c_real, XMIN);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_no_done", n_done - d0, 0);
    run_frame("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mbt_pixel_dispatcher.md
Name: mbt_pixel_dispatcher

Overview:
Frame-level controller that drives one Mandelbrot ALU (start / c_real / c_img in, valid / d_out back) across a full pixel grid. For each pixel it:
- generates the fixed-point coordinate,
- clears and launches the ALU,
- waits for the ALU result,
- writes the 7-bit iteration count to the frame buffer.

It sits between the display/frame-buffer side and the ALU, and is the consumer end of the ALU start/valid protocol.

Parameters:
N, 32, fixed-point word width (two's complement).
Q, 21, fractional bits (1.0 = 32'h0020_0000).
H_RES, 320, pixels per row.
V_RES, 240, rows per frame.
X_MIN, 32'hFFC0_0000, c_real of column 0 (-2.0).
Y_MAX, 32'h0025_8000, c_img of row 0 (+1.171875).
STEP, 32'h0000_2800, coordinate increment per pixel/row.
TIMEOUT, 1023, max WAIT cycles before a forced result.
ADDR_W, 17, frame-buffer address width; H_RES*V_RES must be <= 2^ADDR_W.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
frame_start  in  1  single-cycle request to render one frame.
busy  out  1  high from the accepted frame_start until DONE is left.
frame_done  out  1  one-cycle pulse after the last pixel is written.
timeout_err  out  1  sticky; set when any pixel hit TIMEOUT; cleared on the next accepted frame_start.
alu_rst  out  1  active-high synchronous clear to the ALU.
alu_start  out  1  ALU start strobe.
alu_c_real  out  N  pixel c_real, held stable from CLR through WRITE.
alu_c_img  out  N  pixel c_img, held stable from CLR through WRITE.
alu_valid  in  1  ALU finished (level, sticky until alu_rst).
alu_iter  in  7  ALU iteration count.
fb_we  out  1  frame-buffer write request.
fb_addr  out  ADDR_W  linear pixel address = row*H_RES + col.
fb_data  out  7  iteration count to store.
fb_ready  in  1  frame buffer accepts the write when fb_we && fb_ready.

Behaviour:
Reset values (rst low, asynchronous):
- state = IDLE.
- busy, frame_done, timeout_err, alu_start, fb_we = 0.
- alu_rst = 1, so the ALU is held cleared while idle.
- alu_c_real = X_MIN, alu_c_img = Y_MAX.
- fb_addr = 0, fb_data = 0; col/row/wait counters = 0.

State machine:
- IDLE:
  - alu_rst = 1.
  - On frame_start go to CLR; load col = row = 0, fb_addr = 0, c_real = X_MIN, c_img = Y_MAX; clear timeout_err; set busy.
- CLR: alu_rst = 1 for exactly one cycle -> LAUNCH.
- LAUNCH: alu_rst = 0, alu_start = 1 for exactly one cycle; clear the wait counter -> WAIT.
- WAIT:
  - alu_start = 0; wait counter increments each cycle.
  - If alu_valid = 1, latch fb_data = alu_iter -> WRITE.
  - Else if the wait counter reaches TIMEOUT, latch fb_data = 7'h7F and set timeout_err -> WRITE.
  - If alu_valid and the timeout occur in the same cycle, alu_valid wins.
- WRITE:
  - fb_we = 1, with fb_addr/fb_data stable; hold until fb_ready = 1.
  - On the handshake cycle -> ADVANCE. fb_we drops the cycle after the handshake.
- ADVANCE:
  - If col == H_RES-1 and row == V_RES-1 -> DONE.
  - Else if col == H_RES-1: col = 0, row += 1, c_real = X_MIN, c_img -= STEP.
  - Else: col += 1, c_real += STEP.
  - fb_addr += 1 in both non-final cases; then -> CLR.
- DONE: frame_done = 1 for one cycle, busy = 0 -> IDLE.

Per-pixel cost: 1 (CLR) + 1 (LAUNCH) + W (WAIT, counted through the cycle alu_valid is seen) + F (>= 1, WRITE) + 1 (ADVANCE) cycles.

Rules and boundary conditions:
- Coordinates use wrapping N-bit two's-complement add/sub, with no saturation; parameter choice keeps them in range.
- frame_start while busy: ignored, no restart.
- frame_start on the same cycle as the DONE pulse: ignored; accepted only from IDLE.
- fb_ready low indefinitely: WRITE stalls; no state or data changes.
- alu_valid already high in LAUNCH (stale): impossible by construction because of the CLR cycle; WAIT samples only after LAUNCH.
- rst asserted mid-frame: immediate return to reset values; no partial-frame frame_done.

Decomposition:
- Shared package mbt_pkg:
  - N, Q, the ONE/TWO/FOUR constants, MAX_ITER = 99, the iteration-count width (7).
  - Default viewport constants X_MIN, Y_MAX, STEP.
  - The state enum for this block.
- One natural sub-module: mbt_coord_gen, which holds the col/row counters, c_real/c_img accumulators and fb_addr, with load/advance inputs and last_col/last_pixel flags.
- The FSM and wait counter stay in the top module.

Test Plan:
1. H_RES=4, V_RES=2, STEP=32'h0010_0000, ALU model returns valid 5 cycles after start with iter = pixel index; frame_start -> 8 writes at fb_addr 0..7 with fb_data 0..7; c_real sequence -2.0, -1.5, -1.0, -0.5 per row; c_img 1.171875 then 0.671875 (32'h0015_8000); exactly one frame_done; busy low after.
2. Real ALU, pixel c = (0,0) (X_MIN=0, single pixel) -> fb_data = 99; c = (-2.0+?) pixel at c_real = 32'h0040_0000 (2.0) -> fb_data = 0 or 1 (early escape); timeout_err = 0.
3. ALU model never asserts valid, TIMEOUT=15 -> WRITE entered 16 cycles after LAUNCH, fb_data = 7'h7F, timeout_err = 1 and still 1 after frame_done; next frame_start clears it.
4. fb_ready held low 10 cycles in WRITE -> fb_we held high with constant addr/data for 11 cycles, single accepted write, no address skip.
5. frame_start pulsed again mid-frame -> ignored; total writes = H_RES*V_RES, single frame_done.
6. rst low mid-WAIT -> next edge shows reset values (alu_rst = 1, fb_we = 0, busy = 0, addr 0); a new frame_start after release renders from pixel 0.
